// File: rtl/clarke_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : clarke_arbiter_if
// Brief   : Request, clarke-unit and result signal bundle for clarke_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
interface clarke_arbiter_if #(
    parameter int N_CH    = 3,
    parameter int D_WIDTH = 18
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [N_CH-1:0]         req_valid;
    logic [N_CH*D_WIDTH-1:0] req_a;
    logic [N_CH*D_WIDTH-1:0] req_b;
    logic [N_CH-1:0]         req_ready;
    logic                    cl_start;
    logic [D_WIDTH-1:0]      cl_a;
    logic [D_WIDTH-1:0]      cl_b;
    logic [D_WIDTH-1:0]      cl_alpha;
    logic [D_WIDTH-1:0]      cl_beta;
    logic                    out_valid;
    logic                    out_ready;
    logic [D_WIDTH-1:0]      out_alpha;
    logic [D_WIDTH-1:0]      out_beta;
    logic [CH_W-1:0]         out_ch;
    logic                    busy;

    // Arbiter side
    modport slave (
        input  req_valid, req_a, req_b, cl_alpha, cl_beta, out_ready,
        output req_ready, cl_start, cl_a, cl_b, out_valid, out_alpha, out_beta, out_ch, busy
    );

    // Environment side: sample sources, clarke unit and downstream consumer
    modport master (
        output req_valid, req_a, req_b, cl_alpha, cl_beta, out_ready,
        input  req_ready, cl_start, cl_a, cl_b, out_valid, out_alpha, out_beta, out_ch, busy
    );
endinterface
`default_nettype wire

// File: rtl/clarke_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : clarke_arbiter
// Brief   : Round-robin share of one clarke transform unit between N_CH sources.
// Revision: 1.0 - initial release
// ============================================================================
module clarke_arbiter #(
    parameter int N_CH    = 3,
    parameter int D_WIDTH = 18,
    parameter int LAT     = 1
) (
    input  wire logic        clk,
    input  wire logic        rst,
    clarke_arbiter_if.slave  bus
);
    localparam int c_ch_w  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int c_cnt_w = $clog2(LAT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_ch_w-1:0]   r_rr_ptr;
    logic [c_ch_w-1:0]   r_out_ch;
    logic [c_cnt_w-1:0]  r_wait_cnt;
    logic [D_WIDTH-1:0]  r_cl_a;
    logic [D_WIDTH-1:0]  r_cl_b;
    logic [D_WIDTH-1:0]  r_out_alpha;
    logic [D_WIDTH-1:0]  r_out_beta;
    logic                w_grant_found;
    logic [c_ch_w-1:0]   w_grant_idx;
    logic                w_wait_last;

    // Scan from highest k down so the channel just after rr_ptr wins last.
    always_comb begin : grant_scan
        logic [c_ch_w-1:0] v_idx;
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        v_idx         = '0;
        for (int k = N_CH; k >= 1; k--) begin
            v_idx = c_ch_w'((int'(r_rr_ptr) + k) % N_CH);
            if (bus.req_valid[v_idx]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = v_idx;
            end
        end
    end

    assign w_wait_last = (r_wait_cnt == c_cnt_w'(1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_grant_found) w_state_nxt = ISSUE;
            ISSUE:   w_state_nxt = WAIT;
            WAIT:    if (w_wait_last) w_state_nxt = HOLD;
            HOLD:    if (bus.out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr    <= c_ch_w'(N_CH - 1);
            r_out_ch    <= '0;
            r_wait_cnt  <= '0;
            r_cl_a      <= '0;
            r_cl_b      <= '0;
            r_out_alpha <= '0;
            r_out_beta  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_found) begin
                        r_cl_a   <= bus.req_a[int'(w_grant_idx)*D_WIDTH +: D_WIDTH];
                        r_cl_b   <= bus.req_b[int'(w_grant_idx)*D_WIDTH +: D_WIDTH];
                        r_out_ch <= w_grant_idx;
                    end
                end
                ISSUE: r_wait_cnt <= c_cnt_w'(LAT);
                WAIT: begin
                    r_wait_cnt <= r_wait_cnt - c_cnt_w'(1);
                    if (w_wait_last) begin
                        r_out_alpha <= bus.cl_alpha;
                        r_out_beta  <= bus.cl_beta;
                    end
                end
                HOLD: begin
                    // Pointer moves only on acceptance so a stalled result keeps its priority slot.
                    if (bus.out_ready) r_rr_ptr <= r_out_ch;
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready = (r_state == IDLE && w_grant_found) ? (N_CH'(1) << w_grant_idx) : '0;
    assign bus.cl_start  = (r_state == ISSUE);
    assign bus.cl_a      = r_cl_a;
    assign bus.cl_b      = r_cl_b;
    assign bus.out_valid = (r_state == HOLD);
    assign bus.out_alpha = r_out_alpha;
    assign bus.out_beta  = r_out_beta;
    assign bus.out_ch    = r_out_ch;
    assign bus.busy      = (r_state != IDLE);

endmodule
`default_nettype wire
